vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters: the VGA scan-out path (read-only, deadline driven) and the GPU drawing port (read/write).
- Prefetches scan-out pixels into a small internal FIFO, which the VGA timing generator pops one word per pixel.
- Draw traffic gets the RAM whenever the FIFO has slack. Scan fetches take strict priority once the FIFO falls to a low watermark.
- Sits between the vga block and the VRAM, in the vga pixel-clock domain.

---
 rtl/vram_pkg.sv | 31 +++
 rtl/pix_fifo.sv | 56 +++++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the VRAM arbiter slice.
//   owner_t       - who a returning RAM read belongs to
//   VRAM_*        - default address/data/frame geometry (160x120, RGB 3-3-2)
//   RGB_*         - bit positions of the 3-3-2 colour fields in a pixel word
package vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SCAN,
    OWN_DRAW
  } owner_t;

  localparam int VRAM_AW          = 15;
  localparam int VRAM_DW          = 8;
  localparam int VRAM_FRAME_WORDS = 19200;

  // RGB 3-3-2 layout: rrr_ggg_bb
  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  function automatic logic [7:0] rgb332(input logic [2:0] r,
                                        input logic [2:0] g,
                                        input logic [1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous scan prefetch FIFO with occupancy output.
//   clk, rst (sync, active-low), flush (empties the FIFO, wins over push/pop)
//   push/din  - write a word (caller guarantees space)
//   pop       - consume the head word; ignored while empty
//   head      - current head word, level - occupancy, valid - non-empty
module pix_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  assign head  = mem[rd_ptr_reg];
  assign level = count_reg;
  assign valid = (count_reg != '0);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous VRAM between the VGA scan-out
// prefetcher (read-only, deadline driven) and the GPU draw port (read/write).
//   clk, rst (sync, active-low)
//   frame_start          - restarts scan at word 0, flushes the prefetch FIFO
//   pix_pop/pix_data/pix_valid/underrun - VGA side of the prefetch FIFO
//   draw_req/we/addr/wdata/gnt/rdata/rvalid - GPU draw port
//   mem_addr/we/wdata (registered), mem_rdata (1-cycle latency) - VRAM side
// Optional macro VRAM_ARB_STATS_EN adds draw_stall_cnt (saturating count of
// cycles where draw_req is waiting without a grant).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW          = VRAM_AW,
  parameter int DW          = VRAM_DW,
  parameter int FRAME_WORDS = VRAM_FRAME_WORDS,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_MARK    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_pop,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underrun,
  input  logic          draw_req,
  input  logic          draw_we,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_wdata,
  output logic          draw_gnt,
  output logic [DW-1:0] draw_rdata,
  output logic          draw_rvalid,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]   draw_stall_cnt,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = LW + 1;
  localparam int SW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LOW_C   = CW'(LOW_MARK);
  localparam logic [SW-1:0] FRAME_C = SW'(FRAME_WORDS);

  logic [SW-1:0] scan_addr_reg;
  logic [CW-1:0] inflight_reg;
  logic          epoch_reg;
  owner_t        own1_reg, own2_reg;
  logic          ep1_reg, ep2_reg;
  logic          underrun_reg;

  logic [LW-1:0] level;
  logic [CW-1:0] occupancy;
  logic          scan_ok, urgent, grant_scan, grant_draw;
  logic          ret_scan, ret_draw;

  // Reads already issued count against FIFO space so a push never overflows.
  assign occupancy  = {1'b0, level} + inflight_reg;
  // A scan grant in a frame_start cycle would be thrown away, so never issue it.
  assign scan_ok    = !frame_start && (occupancy < DEPTH_C) && (scan_addr_reg < FRAME_C);
  assign urgent     = scan_ok && (occupancy <= LOW_C);
  assign grant_scan = scan_ok && (urgent || !draw_req);
  assign grant_draw = rst && draw_req && !urgent;
  assign draw_gnt   = grant_draw;

  // Tag stage 2 lines up with mem_rdata; stale-epoch scan data is dropped.
  assign ret_scan    = (own2_reg == OWN_SCAN) && (ep2_reg == epoch_reg);
  assign ret_draw    = rst && (own2_reg == OWN_DRAW);
  assign draw_rvalid = ret_draw;
  assign draw_rdata  = ret_draw ? mem_rdata : '0;
  assign underrun    = underrun_reg;

  pix_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (ret_scan),
    .din   (mem_rdata),
    .pop   (pix_pop),
    .head  (pix_data),
    .level (level),
    .valid (pix_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      scan_addr_reg <= '0;
      inflight_reg  <= '0;
      epoch_reg     <= 1'b0;
      own1_reg      <= OWN_NONE;
      own2_reg      <= OWN_NONE;
      ep1_reg       <= 1'b0;
      ep2_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (grant_scan) begin
        mem_addr <= scan_addr_reg[AW-1:0];
      end else if (grant_draw) begin
        mem_addr  <= draw_addr;
        mem_we    <= draw_we;
        mem_wdata <= draw_wdata;
      end

      if (grant_scan)                  own1_reg <= OWN_SCAN;
      else if (grant_draw && !draw_we) own1_reg <= OWN_DRAW;
      else                             own1_reg <= OWN_NONE;
      ep1_reg  <= epoch_reg;
      own2_reg <= own1_reg;
      ep2_reg  <= ep1_reg;

      if (frame_start) begin
        scan_addr_reg <= '0;
        inflight_reg  <= '0;
        epoch_reg     <= ~epoch_reg;
      end else begin
        if (grant_scan) scan_addr_reg <= scan_addr_reg + SW'(1);
        case ({grant_scan, ret_scan})
          2'b10:   inflight_reg <= inflight_reg + CW'(1);
          2'b01:   inflight_reg <= inflight_reg - CW'(1);
          default: inflight_reg <= inflight_reg;
        endcase
      end

      if (pix_pop && !pix_valid) underrun_reg <= 1'b1;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst || frame_start) begin
      stall_cnt_reg <= '0;
    end else if (draw_req && !draw_gnt && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign draw_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        pix_pop;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        underrun;
  logic        draw_req;
  logic        draw_we;
  logic [14:0] draw_addr;
  logic [7:0]  draw_wdata;
  logic        draw_gnt;
  logic [7:0]  draw_rdata;
  logic        draw_rvalid;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] draw_stall_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  vram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_pop     (pix_pop),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .draw_req    (draw_req),
    .draw_we     (draw_we),
    .draw_addr   (draw_addr),
    .draw_wdata  (draw_wdata),
    .draw_gnt    (draw_gnt),
    .draw_rdata  (draw_rdata),
    .draw_rvalid (draw_rvalid),
`ifdef VRAM_ARB_STATS_EN
    .draw_stall_cnt (draw_stall_cnt),
`endif
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: registered read returning pre-write contents.
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed 0x%0h expected 0x%0h", vectors, tag, obs, exp);
  endtask

  initial begin
    int         bad;
    int         first_bad;
    logic [7:0] exp_w;
    logic [9:0] gnt_tab;
    logic [9:0] rv_tab;

    for (int k = 0; k < 32768; k++) begin
      exp_w  = k[7:0];
      ram[k] = exp_w;
    end
    rst = 1'b0; frame_start = 1'b0; pix_pop = 1'b0;
    draw_req = 1'b0; draw_we = 1'b0; draw_addr = '0; draw_wdata = '0;

    // Reset values
    tick(); tick(); #1;
    chk("rst_mem_addr",    32'(mem_addr), 32'h0);
    chk("rst_mem_we",      32'(mem_we), 32'h0);
    chk("rst_mem_wdata",   32'(mem_wdata), 32'h0);
    chk("rst_pix_valid",   32'(pix_valid), 32'h0);
    chk("rst_underrun",    32'(underrun), 32'h0);
    chk("rst_draw_rvalid", 32'(draw_rvalid), 32'h0);
    chk("rst_draw_rdata",  32'(draw_rdata), 32'h0);

    // Fill after reset: words 0..7, then idle
    rst = 1'b1;                                   // cycle R0
    tick(); #1;                                   // R1
    chk("fill_r1_valid", 32'(pix_valid), 32'h0);
    tick(); tick(); #1;                           // R3
    chk("fill_r3_valid", 32'(pix_valid), 32'h1);
    chk("fill_r3_addr",  32'(mem_addr), 32'h2);
    for (int i = 0; i < 9; i++) tick();           // R12
    #1;
    chk("fill_last_addr", 32'(mem_addr), 32'h7);
    chk("fill_head",      32'(pix_data), 32'h0);
    tick(); tick(); #1;                           // R14
    chk("fill_idle_addr", 32'(mem_addr), 32'h7);
    chk("fill_idle_we",   32'(mem_we), 32'h0);

    // Full frame streamed at one pop per cycle
    frame_start = 1'b1;
    tick(); frame_start = 1'b0; #1;
    chk("fs_flush_valid", 32'(pix_valid), 32'h0);
    for (int i = 0; i < 14; i++) tick();
    bad = 0; first_bad = -1;
    for (int k = 0; k < 19200; k++) begin
      pix_pop = 1'b1;
      #1;
      exp_w = k[7:0];
      if (!(pix_valid === 1'b1 && pix_data === exp_w)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      tick();
    end
    pix_pop = 1'b0; #1;
    chk("stream_bad_words", 32'(bad), 32'h0);
    chk("stream_underrun",  32'(underrun), 32'h0);
    chk("stream_end_valid", 32'(pix_valid), 32'h0);
    chk("stream_end_addr",  32'(mem_addr), 32'd19199);
    chk("stream_end_we",    32'(mem_we), 32'h0);

    // frame_start with two scan reads in flight
    frame_start = 1'b1;                           // G
    tick(); frame_start = 1'b0;                   // G+1
    tick(); tick(); tick(); #1;                   // G+4
    chk("fs2_pre_valid", 32'(pix_valid), 32'h1);
    chk("fs2_pre_head",  32'(pix_data), 32'h0);
    frame_start = 1'b1;
    tick(); frame_start = 1'b0; #1;               // G+5
    chk("fs2_g5_valid", 32'(pix_valid), 32'h0);
    chk("fs2_g5_addr",  32'(mem_addr), 32'h2);
    tick(); #1;                                   // G+6
    chk("fs2_g6_valid", 32'(pix_valid), 32'h0);
    chk("fs2_g6_addr",  32'(mem_addr), 32'h0);
    tick(); #1;                                   // G+7
    chk("fs2_g7_valid", 32'(pix_valid), 32'h0);
    tick(); #1;                                   // G+8
    chk("fs2_g8_valid", 32'(pix_valid), 32'h1);
    chk("fs2_g8_head",  32'(pix_data), 32'h0);
    for (int i = 0; i < 12; i++) tick();          // D

    // Draw write then read back with FIFO full
    draw_req = 1'b1; draw_we = 1'b1; draw_addr = 15'h0100; draw_wdata = 8'hA5;
    #1;
    chk("wr_gnt", 32'(draw_gnt), 32'h1);
    tick(); draw_req = 1'b0; draw_we = 1'b0; #1;
    chk("wr_mem_we",    32'(mem_we), 32'h1);
    chk("wr_mem_addr",  32'(mem_addr), 32'h100);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    tick(); #1;
    chk("wr_mem_we_off", 32'(mem_we), 32'h0);
    tick();                                       // E
    draw_req = 1'b1; draw_we = 1'b0; draw_addr = 15'h0100; draw_wdata = 8'h00;
    #1;
    chk("rd_gnt", 32'(draw_gnt), 32'h1);
    tick(); draw_req = 1'b0; #1;
    chk("rd_e1_rvalid", 32'(draw_rvalid), 32'h0);
    tick(); #1;
    chk("rd_e2_rvalid", 32'(draw_rvalid), 32'h1);
    chk("rd_e2_rdata",  32'(draw_rdata), 32'hA5);
    tick(); #1;
    chk("rd_e3_rvalid", 32'(draw_rvalid), 32'h0);
    tick();                                       // S0

    // Contention: pops drain the FIFO while draw_req is held
    gnt_tab = 10'b10_0011_1111;                   // bit i = cycle Si
    rv_tab  = 10'b00_1111_1100;
    for (int i = 0; i < 10; i++) begin
      draw_req = 1'b1; draw_we = 1'b0; draw_addr = 15'h1242;
      pix_pop = (i < 8);
      #1;
      chk($sformatf("arb_s%0d_gnt", i), 32'(draw_gnt), 32'(gnt_tab[i]));
      chk($sformatf("arb_s%0d_rvalid", i), 32'(draw_rvalid), 32'(rv_tab[i]));
      if (rv_tab[i]) chk($sformatf("arb_s%0d_rdata", i), 32'(draw_rdata), 32'h42);
      if (i < 8) chk($sformatf("arb_s%0d_pix", i), 32'(pix_data), 32'(i));
      if (i == 7) chk("arb_s7_addr", 32'(mem_addr), 32'h8);
      if (i == 9) chk("arb_s9_addr", 32'(mem_addr), 32'hA);
      tick();
    end
    draw_req = 1'b0; pix_pop = 1'b0; #1;
    chk("arb_underrun", 32'(underrun), 32'h0);
`ifdef VRAM_ARB_STATS_EN
    chk("arb_stall_cnt", 32'(draw_stall_cnt), 32'h3);
`endif
    for (int i = 0; i < 15; i++) tick();          // X

    // Reset while a draw read is in flight, then pop on empty FIFO
    draw_req = 1'b1; draw_we = 1'b0; draw_addr = 15'h0077; draw_wdata = 8'h5A;
    #1;
    chk("rr_gnt", 32'(draw_gnt), 32'h1);
    tick(); draw_req = 1'b0; rst = 1'b0; #1;      // X+1
    chk("rr_mem_addr",  32'(mem_addr), 32'h77);
    chk("rr_mem_wdata", 32'(mem_wdata), 32'h5A);
    tick(); #1;                                   // X+2
    chk("rr_rvalid",     32'(draw_rvalid), 32'h0);
    chk("rr_mem_addr0",  32'(mem_addr), 32'h0);
    chk("rr_mem_wdata0", 32'(mem_wdata), 32'h0);
    chk("rr_pix_valid",  32'(pix_valid), 32'h0);
    rst = 1'b1; pix_pop = 1'b1; #1;               // R0 with pop on empty
    tick(); pix_pop = 1'b0; #1;                   // R1
    chk("ur_set",      32'(underrun), 32'h1);
    chk("ur_r1_valid", 32'(pix_valid), 32'h0);
    tick(); #1;                                   // R2
    chk("ur_r2_valid", 32'(pix_valid), 32'h0);
    tick(); #1;                                   // R3
    chk("ur_r3_valid", 32'(pix_valid), 32'h1);
    chk("ur_r3_head",  32'(pix_data), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("ur_sticky", 32'(underrun), 32'h1);

    if (first_bad >= 0) $display("stream first bad word index %0d", first_bad);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
